// File: rtl/led_display_pkg.sv
// Shared constants for the four-digit seven-segment display peripheral:
// default bus address, active-low segment codes and anode encodings.
package led_display_pkg;

    localparam logic [7:0] DEFAULT_BASE_ADDR = 8'hD0;

    // Which of the four digit positions the scan is currently driving.
    typedef enum logic [1:0] {
        DIGIT0 = 2'd0,
        DIGIT1 = 2'd1,
        DIGIT2 = 2'd2,
        DIGIT3 = 2'd3
    } digit_e;

    // Active-low segment codes, bit order g..a (bit0 = segment a).
    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h10;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;

    // Decimal point cathode level when unlit, and a fully blank digit.
    localparam logic       DP_OFF    = 1'b1;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low anode selects; bit3 is the leftmost digit.
    localparam logic [3:0] SEL_DIGIT0 = 4'b1110;
    localparam logic [3:0] SEL_DIGIT1 = 4'b1101;
    localparam logic [3:0] SEL_DIGIT2 = 4'b1011;
    localparam logic [3:0] SEL_DIGIT3 = 4'b0111;
    localparam logic [3:0] SEL_NONE   = 4'b1111;

    // Anode pattern that lights exactly the given digit position.
    function automatic logic [3:0] digit_select(input digit_e digit);
        logic [3:0] sel;
        sel = SEL_NONE;
        case (digit)
            DIGIT0:  sel = SEL_DIGIT0;
            DIGIT1:  sel = SEL_DIGIT1;
            DIGIT2:  sel = SEL_DIGIT2;
            DIGIT3:  sel = SEL_DIGIT3;
            default: sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/led_display_seg7_decoder.sv
// Hex nibble to active-low seven-segment pattern (g..a), purely combinational.
module seg7_decoder
    import led_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    // Table lookup of the glyph for each hex value 0-F.
    always_comb begin
        segments = SEG_HEX_0;
        case (nibble)
            4'h0:    segments = SEG_HEX_0;
            4'h1:    segments = SEG_HEX_1;
            4'h2:    segments = SEG_HEX_2;
            4'h3:    segments = SEG_HEX_3;
            4'h4:    segments = SEG_HEX_4;
            4'h5:    segments = SEG_HEX_5;
            4'h6:    segments = SEG_HEX_6;
            4'h7:    segments = SEG_HEX_7;
            4'h8:    segments = SEG_HEX_8;
            4'h9:    segments = SEG_HEX_9;
            4'hA:    segments = SEG_HEX_A;
            4'hB:    segments = SEG_HEX_B;
            4'hC:    segments = SEG_HEX_C;
            4'hD:    segments = SEG_HEX_D;
            4'hE:    segments = SEG_HEX_E;
            4'hF:    segments = SEG_HEX_F;
            default: segments = SEG_HEX_0;
        endcase
    end

endmodule

// File: rtl/led_display.sv
// Memory-mapped four-digit seven-segment display. Two write-only byte
// registers hold four hex digits that are time-multiplexed onto a
// common-anode display with active-low anodes and cathodes.
module led_display
    import led_display_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int         SCAN_BITS = 12
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] BUS_ADDR,
    input  logic [7:0] BUS_DATA,
    input  logic       BUS_WE,
    output logic [3:0] DISP_SEL_OUT,
    output logic [7:0] DISP_OUT
);

    localparam logic [7:0] RIGHT_ADDR = BASE_ADDR + 8'd1;

    logic [7:0]           left_reg;
    logic [7:0]           right_reg;
    logic [SCAN_BITS-1:0] scan_cnt;
    digit_e               scan_digit;
    logic [3:0]           scan_nibble;
    logic [6:0]           scan_segments;

    // Capture bus writes aimed at either of the two digit-pair registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            left_reg  <= 8'h00;
            right_reg <= 8'h00;
        end else if (BUS_WE) begin
            if (BUS_ADDR == BASE_ADDR) begin
                left_reg <= BUS_DATA;
            end else if (BUS_ADDR == RIGHT_ADDR) begin
                right_reg <= BUS_DATA;
            end
        end
    end

    // Free-running refresh counter; its top two bits pick the lit digit.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + SCAN_BITS'(1);
        end
    end

    assign scan_digit = digit_e'(scan_cnt[SCAN_BITS-1 -: 2]);

    // Route the nibble belonging to the currently scanned digit.
    always_comb begin
        scan_nibble = right_reg[3:0];
        case (scan_digit)
            DIGIT0:  scan_nibble = right_reg[3:0];
            DIGIT1:  scan_nibble = right_reg[7:4];
            DIGIT2:  scan_nibble = left_reg[3:0];
            DIGIT3:  scan_nibble = left_reg[7:4];
            default: scan_nibble = right_reg[3:0];
        endcase
    end

    seg7_decoder u_seg7_decoder (
        .nibble   (scan_nibble),
        .segments (scan_segments)
    );

    // Register anode and cathode together so they switch on the same edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            DISP_SEL_OUT <= SEL_NONE;
            DISP_OUT     <= SEG_BLANK;
        end else begin
            DISP_SEL_OUT <= digit_select(scan_digit);
            DISP_OUT     <= {DP_OFF, scan_segments};
        end
    end

endmodule

// File: tb/tb_led_display.sv
// Directed self-checking bench for led_display: reset blanking, register
// writes, address decode, full hex glyph sweep, scan order/dwell and
// asynchronous reset in the middle of a scan.
module tb_led_display;

    logic       CLK;
    logic       RESET;
    logic [7:0] BUS_ADDR;
    logic [7:0] BUS_DATA;
    logic       BUS_WE;
    logic [3:0] DISP_SEL_OUT;
    logic [7:0] DISP_OUT;

    int vectors;
    int miscompares;

    // One observation per digit over a full frame of the display.
    logic [3:0] cap_sel [4];
    logic [7:0] cap_seg [4];
    bit         cap_ok;

    // Expected segment bytes, packed digit3..digit0 from MSB to LSB.
    logic [31:0] exp_word;
    logic [7:0]  exp_seg;

    led_display dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .BUS_ADDR     (BUS_ADDR),
        .BUS_DATA     (BUS_DATA),
        .BUS_WE       (BUS_WE),
        .DISP_SEL_OUT (DISP_SEL_OUT),
        .DISP_OUT     (DISP_OUT)
    );

    // 100 MHz system clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected cathode byte for an observed anode pattern; an illegal
    // pattern maps to a value the display can never legally produce.
    function automatic logic [7:0] expected_seg(input logic [3:0] sel, input logic [31:0] word);
        logic [7:0] seg;
        seg = 8'h00;
        case (sel)
            4'b1110: seg = word[7:0];
            4'b1101: seg = word[15:8];
            4'b1011: seg = word[23:16];
            4'b0111: seg = word[31:24];
            default: seg = 8'h00;
        endcase
        return seg;
    endfunction

    // One bus cycle driven at the falling edge, sampled at the next rising edge.
    task automatic bus_cycle(input logic [7:0] addr, input logic [7:0] data, input logic we);
        @(negedge CLK);
        BUS_ADDR = addr;
        BUS_DATA = data;
        BUS_WE   = we;
        @(negedge CLK);
        BUS_ADDR = 8'hFF;
        BUS_WE   = 1'b0;
    endtask

    // Walk one whole frame, sampling each digit one cycle into its dwell.
    task automatic capture_frame();
        logic [3:0] prev;
        int n;
        cap_ok = 1'b1;
        prev = DISP_SEL_OUT;
        n = 0;
        while (DISP_SEL_OUT == prev && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 2000) cap_ok = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            cap_sel[k] = DISP_SEL_OUT;
            cap_seg[k] = DISP_OUT;
            if (k < 3) begin
                prev = DISP_SEL_OUT;
                n = 0;
                while (DISP_SEL_OUT == prev && n < 2000) begin
                    @(negedge CLK);
                    n++;
                end
                if (n >= 2000) cap_ok = 1'b0;
            end
        end
    endtask

    // Outputs blank during reset, then every digit shows 0 afterwards.
    task automatic test_reset();
        RESET    = 1'b0;
        BUS_ADDR = 8'hFF;
        BUS_DATA = 8'h00;
        BUS_WE   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            vectors++;
            if (DISP_SEL_OUT !== 4'hF || DISP_OUT !== 8'hFF) begin
                miscompares++;
                $display("[TB] FAIL reset_hold: sel=%b out=%h, required sel=1111 out=ff", DISP_SEL_OUT, DISP_OUT);
            end
        end
        #2 RESET = 1'b1;
        exp_word = 32'hC0C0C0C0;
        capture_frame();
        vectors++;
        if (!cap_ok) begin
            miscompares++;
            $display("[TB] FAIL reset_scan_timeout: scan stalled at sel=%b", DISP_SEL_OUT);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            exp_seg = expected_seg(cap_sel[k], exp_word);
            if (cap_seg[k] !== exp_seg) begin
                miscompares++;
                $display("[TB] FAIL reset_digit: sel=%b out=%h, required %h", cap_sel[k], cap_seg[k], exp_seg);
            end
        end
    endtask

    // Writing FF to the left register lights F on both left digits.
    task automatic test_left_write();
        bus_cycle(8'hD0, 8'hFF, 1'b1);
        exp_word = 32'h8E8EC0C0;
        capture_frame();
        vectors++;
        if (!cap_ok) begin
            miscompares++;
            $display("[TB] FAIL left_scan_timeout: scan stalled at sel=%b", DISP_SEL_OUT);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            exp_seg = expected_seg(cap_sel[k], exp_word);
            if (cap_seg[k] !== exp_seg) begin
                miscompares++;
                $display("[TB] FAIL left_digit: sel=%b out=%h, required %h", cap_sel[k], cap_seg[k], exp_seg);
            end
        end
    endtask

    // Writing F0 to the right register lights F on digit1, 0 on digit0.
    task automatic test_right_write();
        bus_cycle(8'hD1, 8'hF0, 1'b1);
        exp_word = 32'h8E8E8EC0;
        capture_frame();
        vectors++;
        if (!cap_ok) begin
            miscompares++;
            $display("[TB] FAIL right_scan_timeout: scan stalled at sel=%b", DISP_SEL_OUT);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            exp_seg = expected_seg(cap_sel[k], exp_word);
            if (cap_seg[k] !== exp_seg) begin
                miscompares++;
                $display("[TB] FAIL right_digit: sel=%b out=%h, required %h", cap_sel[k], cap_seg[k], exp_seg);
            end
        end
    endtask

    // Two full frames: each select held 1024 cycles, in ascending digit order.
    task automatic test_scan_dwell();
        logic [3:0] order [4];
        int n;
        order[0] = 4'b1110;
        order[1] = 4'b1101;
        order[2] = 4'b1011;
        order[3] = 4'b0111;
        n = 0;
        while (DISP_SEL_OUT == 4'b1110 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        n = 0;
        while (DISP_SEL_OUT != 4'b1110 && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        for (int i = 0; i < 8; i++) begin
            n = 0;
            while (DISP_SEL_OUT == order[i % 4] && n < 1100) begin
                n++;
                @(negedge CLK);
            end
            vectors++;
            if (n !== 1024) begin
                miscompares++;
                $display("[TB] FAIL scan_dwell: select %b held %0d cycles, required 1024", order[i % 4], n);
            end
        end
        vectors++;
        if (DISP_SEL_OUT !== 4'b1110) begin
            miscompares++;
            $display("[TB] FAIL scan_wrap: sel=%b after two frames, required 1110", DISP_SEL_OUT);
        end
    endtask

    // Writes to foreign addresses or with WE low leave the display alone.
    task automatic test_address_decode();
        bus_cycle(8'hD2, 8'h55, 1'b1);
        bus_cycle(8'hCF, 8'h55, 1'b1);
        bus_cycle(8'hFF, 8'h55, 1'b1);
        bus_cycle(8'hD0, 8'h12, 1'b0);
        exp_word = 32'h8E8E8EC0;
        capture_frame();
        vectors++;
        if (!cap_ok) begin
            miscompares++;
            $display("[TB] FAIL decode_scan_timeout: scan stalled at sel=%b", DISP_SEL_OUT);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            exp_seg = expected_seg(cap_sel[k], exp_word);
            if (cap_seg[k] !== exp_seg) begin
                miscompares++;
                $display("[TB] FAIL decode_digit: sel=%b out=%h, required %h", cap_sel[k], cap_seg[k], exp_seg);
            end
        end
    endtask

    // Every hex glyph 0-F appears once across four register pairs.
    task automatic test_decoder_sweep();
        logic [7:0]  left_val  [4];
        logic [7:0]  right_val [4];
        logic [31:0] glyphs    [4];
        left_val[0] = 8'h01; right_val[0] = 8'h23; glyphs[0] = 32'hC0F9A4B0;
        left_val[1] = 8'h45; right_val[1] = 8'h67; glyphs[1] = 32'h999282F8;
        left_val[2] = 8'h89; right_val[2] = 8'hAB; glyphs[2] = 32'h80908883;
        left_val[3] = 8'hCD; right_val[3] = 8'hEF; glyphs[3] = 32'hC6A1868E;
        for (int c = 0; c < 4; c++) begin
            bus_cycle(8'hD0, left_val[c], 1'b1);
            bus_cycle(8'hD1, right_val[c], 1'b1);
            exp_word = glyphs[c];
            capture_frame();
            vectors++;
            if (!cap_ok) begin
                miscompares++;
                $display("[TB] FAIL sweep_scan_timeout: case %0d stalled at sel=%b", c, DISP_SEL_OUT);
            end
            for (int k = 0; k < 4; k++) begin
                vectors++;
                exp_seg = expected_seg(cap_sel[k], exp_word);
                if (cap_seg[k] !== exp_seg) begin
                    miscompares++;
                    $display("[TB] FAIL sweep_digit: case %0d sel=%b out=%h, required %h", c, cap_sel[k], cap_seg[k], exp_seg);
                end
            end
        end
    endtask

    // Reset between clock edges blanks at once and clears both registers.
    task automatic test_reset_mid_scan();
        @(negedge CLK);
        #2 RESET = 1'b0;
        #1;
        vectors++;
        if (DISP_SEL_OUT !== 4'hF || DISP_OUT !== 8'hFF) begin
            miscompares++;
            $display("[TB] FAIL async_reset: sel=%b out=%h, required sel=1111 out=ff", DISP_SEL_OUT, DISP_OUT);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            vectors++;
            if (DISP_SEL_OUT !== 4'hF || DISP_OUT !== 8'hFF) begin
                miscompares++;
                $display("[TB] FAIL async_reset_hold: sel=%b out=%h, required sel=1111 out=ff", DISP_SEL_OUT, DISP_OUT);
            end
        end
        #2 RESET = 1'b1;
        exp_word = 32'hC0C0C0C0;
        capture_frame();
        vectors++;
        if (!cap_ok) begin
            miscompares++;
            $display("[TB] FAIL post_reset_timeout: scan stalled at sel=%b", DISP_SEL_OUT);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            exp_seg = expected_seg(cap_sel[k], exp_word);
            if (cap_seg[k] !== exp_seg) begin
                miscompares++;
                $display("[TB] FAIL post_reset_digit: sel=%b out=%h, required %h", cap_sel[k], cap_seg[k], exp_seg);
            end
        end
    endtask

    // Run every scenario in order and report the totals.
    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_left_write();
        test_right_write();
        test_scan_dwell();
        test_address_decode();
        test_decoder_sweep();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_display.md
Name: led_display

Overview:
- Memory-mapped 4-digit seven-segment display peripheral on the processor data bus.
- Two byte registers hold four hex digits. The block time-multiplexes them onto a common-anode 4-digit display (Basys3-style, active-low anodes and cathodes).
- Write-only bus slave: never drives BUS_DATA.

Parameters:
- BASE_ADDR, 8'hD0, address of left byte; right byte at BASE_ADDR+1 (8'hD1).
- SCAN_BITS, 12, width of the free-running refresh counter; top 2 bits select the digit (default: 1024 cycles per digit, 10.24 us at 100 MHz).

Ports:
- CLK  input  1  system clock, 100 MHz, rising-edge.
- RESET  input  1  asynchronous, active-low reset.
- BUS_ADDR  input  8  bus address from processor.
- BUS_DATA  input  8  bus write data (sampled only, never driven).
- BUS_WE  input  1  bus write enable, active-high.
- DISP_SEL_OUT  output  4  digit anode select, active-low one-hot; bit3 = leftmost digit.
- DISP_OUT  output  8  segment cathodes, active-low; [6:0] = g..a (bit0 = a), [7] = decimal point.

Behaviour:
- Reset (RESET=0, asynchronous):
  - left_reg = right_reg = 8'h00; scan counter = 0.
  - DISP_SEL_OUT = 4'b1111 (all digits off); DISP_OUT = 8'hFF (blank).
  - Outputs hold these values while RESET is low; normal operation resumes on the first CLK edge after RESET returns high.
- Bus write, sampled on CLK rising edge:
  - BUS_WE=1 and BUS_ADDR==BASE_ADDR -> left_reg <= BUS_DATA.
  - BUS_WE=1 and BUS_ADDR==BASE_ADDR+1 -> right_reg <= BUS_DATA.
  - Any other address, or BUS_WE=0 -> no change. A single-cycle WE pulse is sufficient.
  - Register updates are visible at the outputs no later than the next time the affected digit is scanned.
- Digit mapping:
  - digit3 = left_reg[7:4]; digit2 = left_reg[3:0]; digit1 = right_reg[7:4]; digit0 = right_reg[3:0].
- Scan:
  - Counter increments every cycle and wraps from 2^SCAN_BITS-1 to 0.
  - sel = counter[SCAN_BITS-1:SCAN_BITS-2].
  - sel 0 -> digit0, DISP_SEL_OUT=4'b1110; 1 -> digit1, 4'b1101; 2 -> digit2, 4'b1011; 3 -> digit3, 4'b0111.
  - DISP_SEL_OUT and DISP_OUT are both registered, so they change on the same edge with no glitch between anode and segment data. Latency is one cycle from the counter field to the outputs.
- Decode, DISP_OUT with dp off (bit7=1):
  - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
  - 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E
- Decimal point is always off.
- A write that coincides with the digit switch is taken. The newly selected digit shows either the old or the new value for that one cycle, and the new value from then on.

Decomposition:
- Shared package: BASE_ADDR default, seven-segment active-low code constants, digit-select encodings.
- One sub-module: seg7_decoder, purely combinational 4-bit hex nibble -> 7-bit active-low segments. The top level adds the dp bit.
- Top level contains the bus registers, scan counter and output registers.

Test Plan:
- Reset: hold RESET=0 for 100 ns -> DISP_SEL_OUT=4'hF, DISP_OUT=8'hFF throughout. After release with no writes, scanning all digits -> DISP_OUT=8'hC0 on each of 1110/1101/1011/0111.
- Left write: BUS_ADDR=D0, WE=1, DATA=FF for one cycle, then ADDR=FF, WE=0 -> DISP_OUT=8E when DISP_SEL_OUT=0111 and 1011; right digits remain C0.
- Right write: ADDR=D1, WE=1, DATA=F0 one cycle -> 1101 shows 8E, 1110 shows C0. Over 100 us all four selects are seen, each held for 1024 cycles, in order 1110->1101->1011->0111 and repeating.
- Address decode: WE=1 to D2, CF, FF with DATA=55 -> display unchanged. WE=0 at D0 with DATA=12 -> unchanged.
- Decoder sweep: write D0=01,23,45,67,89,AB,CD,EF across D0/D1 -> each digit shows its table code exactly; DISP_SEL_OUT is always one-hot-low.
- Reset mid-scan: assert RESET while digits are lit -> outputs go to F/FF immediately without a clock edge; registers are cleared to 00 after release.
